// File: rtl/vec_mem_pkg.sv
// Shared constants, FSM state encoding and the base-address range check
// used by the vector memory controller.
package vec_mem_pkg;

  localparam int ADDR_W = 9;
  localparam int WORD_W = 32;
  localparam int LANES  = 16;
  localparam int VEC_W  = WORD_W * LANES;

  // Highest base address whose LANES words all fit below 2**ADDR_W.
  localparam logic [ADDR_W-1:0] MAX_BASE = ADDR_W'((1 << ADDR_W) - LANES);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WR_ISSUE   = 3'd1,
    ST_RD_ISSUE   = 3'd2,
    ST_RD_CAPTURE = 3'd3,
    ST_RESP       = 3'd4
  } state_t;

  // True when a vector starting at 'base' stays inside the memory.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] base);
    return (base <= MAX_BASE);
  endfunction

endpackage

// File: rtl/vec_mem_ctrl.sv
// Single-outstanding vector load/store initiator for the vector data memory.
// Takes one request at a time, drives the memory port for exactly one cycle,
// and returns one response per request.
// Optional build macro MEM_BOUND_CHECK_EN: rejects requests whose vector
// would run past the top of memory, answering with resp_err after one cycle
// without touching memory.
module vec_mem_ctrl
  import vec_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [VEC_W-1:0]  req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_we,
  output logic [VEC_W-1:0]  resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [VEC_W-1:0]  mem_data_in,
  input  logic [VEC_W-1:0]  mem_data_out
);

  state_t state_q;

  // Ready depends on state only so the requester never sees a combinational
  // loop through req_valid.
  assign req_ready = (state_q == ST_IDLE);

  // Request FSM with registered memory-port and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      resp_valid       <= 1'b0;
      resp_we          <= 1'b0;
      resp_err         <= 1'b0;
      resp_rdata       <= '0;
      mem_address      <= '0;
      mem_data_in      <= '0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
    end else begin
      // Enables are single-cycle pulses; only the accept edge raises one.
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            resp_we     <= req_we;
            resp_err    <= 1'b0;
            mem_address <= req_addr;
`ifdef MEM_BOUND_CHECK_EN
            if (!addr_in_range(req_addr)) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state_q    <= ST_RESP;
            end else
`endif
            begin
              if (req_we) begin
                mem_data_in      <= req_wdata;
                mem_write_enable <= 1'b1;
                state_q          <= ST_WR_ISSUE;
              end else begin
                mem_read_enable  <= 1'b1;
                state_q          <= ST_RD_ISSUE;
              end
            end
          end
        end
        ST_WR_ISSUE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state_q    <= ST_RESP;
        end
        ST_RD_ISSUE: begin
          // Memory registers its output on this edge.
          state_q <= ST_RD_CAPTURE;
        end
        ST_RD_CAPTURE: begin
          resp_rdata <= mem_data_out;
          resp_valid <= 1'b1;
          state_q    <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
